// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: FSM states, funct3 load/store length codes
// and lane/alignment helpers.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LEN_B  = 3'b000;
    localparam logic [2:0] LEN_H  = 3'b001;
    localparam logic [2:0] LEN_W  = 3'b010;
    localparam logic [2:0] LEN_BU = 3'b100;
    localparam logic [2:0] LEN_HU = 3'b101;

    function automatic logic is_byte(input logic [2:0] len);
        return len[1:0] == LEN_B[1:0];
    endfunction

    function automatic logic is_half(input logic [2:0] len);
        return len[1:0] == LEN_H[1:0];
    endfunction

    function automatic logic is_word(input logic [2:0] len);
        return len[1:0] == LEN_W[1:0];
    endfunction

    // Active-low {UB_N, LB_N} for the low phase; odd bytes live on the upper lane.
    function automatic logic [1:0] lane_n(input logic [2:0] len, input logic a0);
        return is_byte(len) ? {~a0, a0} : 2'b00;
    endfunction

    function automatic logic misaligned(input logic [2:0] len, input logic [1:0] a,
                                        input logic both);
        return (is_half(len) && a[0]) || (is_word(len) && (a != 2'b00)) || both;
    endfunction

endpackage

// File: rtl/sram_ctrl_load_extend.sv
// Combinational load formatter: selects the addressed byte/halfword and sign/zero-extends
// it, or concatenates both halves for a word.
module load_extend
    import sram_ctrl_pkg::*;
(
    input  logic [15:0] lo_i,
    input  logic [15:0] hi_i,
    input  logic [2:0]  len_i,
    input  logic        a0_i,
    output logic [31:0] result_o
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = a0_i ? lo_i[15:8] : lo_i[7:0];
        if (is_word(len_i)) begin
            result_o = {hi_i, lo_i};
        end else if (is_byte(len_i)) begin
            result_o = {{24{~len_i[2] & byte_sel[7]}}, byte_sel};
        end else begin
            result_o = {{16{~len_i[2] & lo_i[15]}}, lo_i};
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage to 16-bit async SRAM sequencer (IDLE->LO->HI->DONE).
// Optional macro SRAM_MISALIGN_TRAP_EN: misaligned or rd&wr requests skip the SRAM and pulse err.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int                 WIDTH       = 32,
    parameter int                 SRAM_AW     = 20,
    parameter logic [WIDTH-1:0]   BASE_ADDR   = 32'h100,
    parameter int                 WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      mem_addr,
    input  logic [WIDTH-1:0]      mem_wdata,
    input  logic [2:0]            mem_len,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    output logic [WIDTH-1:0]      mem_rdata,
    output logic                  stall,
    output logic                  err,
    output logic [SRAM_AW-1:0]    SRAM_ADDR,
    inout  wire  [15:0]           SRAM_DQ,
    output logic                  SRAM_CE_N,
    output logic                  SRAM_OE_N,
    output logic                  SRAM_WE_N,
    output logic                  SRAM_UB_N,
    output logic                  SRAM_LB_N
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SRAM_AW:0]   addr_q, addr_d;
    logic [2:0]         len_q, len_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic [15:0]        lo_q, lo_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;

    logic               req;
    logic               last;
    logic               phase_hi;
    logic [SRAM_AW:0]   addr_in;
    logic               dq_oe;
    logic [15:0]        dq_out;
    logic [15:0]        dq_in;
    logic [31:0]        ext_result;

    assign req      = (mem_addr >= BASE_ADDR) && (mem_rd || mem_wr);
    assign last     = (cnt_q == CW'(WAIT_CYCLES));
    assign phase_hi = (state_q == ST_HI);
    assign dq_in    = SRAM_DQ;
    assign SRAM_DQ  = dq_oe ? dq_out : 16'hzzzz;
    assign mem_rdata = rdata_q;

`ifdef SRAM_MISALIGN_TRAP_EN
    logic err_q, err_d;
    logic misalign;
    assign misalign = misaligned(mem_len, mem_addr[1:0], mem_rd & mem_wr);
    assign addr_in  = mem_addr[SRAM_AW:0];
    assign err      = (state_q == ST_DONE) && err_q;
`else
    // Without the trap, misaligned halfwords/words are silently rounded down.
    always_comb begin
        addr_in = mem_addr[SRAM_AW:0];
        if (is_half(mem_len)) addr_in[0] = 1'b0;
        if (is_word(mem_len)) addr_in[1:0] = 2'b00;
    end
    assign err = 1'b0;
`endif

    // For words the low half was captured earlier; the bus now carries the high half.
    load_extend u_load_extend (
        .lo_i     (phase_hi ? lo_q : dq_in),
        .hi_i     (dq_in),
        .len_i    (len_q),
        .a0_i     (addr_q[0]),
        .result_o (ext_result)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        lo_d      = lo_q;
        rdata_d   = rdata_q;
`ifdef SRAM_MISALIGN_TRAP_EN
        err_d     = err_q;
`endif
        stall     = 1'b0;
        SRAM_ADDR = '0;
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    stall   = 1'b1;
                    addr_d  = addr_in;
                    len_d   = mem_len;
                    wdata_d = mem_wdata;
                    wr_d    = mem_wr;
                    cnt_d   = '0;
                    state_d = ST_LO;
`ifdef SRAM_MISALIGN_TRAP_EN
                    err_d   = misalign;
                    if (misalign) state_d = ST_DONE;
`endif
                end
            end
            ST_LO, ST_HI: begin
                stall     = 1'b1;
                SRAM_CE_N = 1'b0;
                SRAM_ADDR = addr_q[SRAM_AW:1] + SRAM_AW'(phase_hi);
                {SRAM_UB_N, SRAM_LB_N} = phase_hi ? 2'b00 : lane_n(len_q, addr_q[0]);
                if (wr_q) begin
                    dq_oe     = 1'b1;
                    SRAM_WE_N = (cnt_q == '0);
                    if (phase_hi)             dq_out = wdata_q[WIDTH-1:WIDTH-16];
                    else if (is_byte(len_q))  dq_out = {2{wdata_q[7:0]}};
                    else                      dq_out = wdata_q[15:0];
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                if (last) begin
                    cnt_d = '0;
                    if (!phase_hi && is_word(len_q)) begin
                        state_d = ST_HI;
                        if (!wr_q) lo_d = dq_in;
                    end else begin
                        state_d = ST_DONE;
                        if (!wr_q) rdata_d = ext_result;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            lo_q    <= '0;
            rdata_q <= '0;
`ifdef SRAM_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
`ifdef SRAM_MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule
